// File: rtl/exc_pkg.sv
// Shared types and constants for the cp0 exception controller.
package exc_pkg;

    localparam int unsigned EXC_VEC_W = 6;

    // Bit positions inside the {eret,ovf,trap,brk,syscall,ri} flag vector
    localparam int unsigned EXC_BIT_RI      = 0;
    localparam int unsigned EXC_BIT_SYSCALL = 1;
    localparam int unsigned EXC_BIT_BRK     = 2;
    localparam int unsigned EXC_BIT_TRAP    = 3;
    localparam int unsigned EXC_BIT_OVF     = 4;
    localparam int unsigned EXC_BIT_ERET    = 5;

    localparam logic [4:0] CP0_ADDR_STATUS = 5'd12;
    localparam logic [4:0] CP0_ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_ADDR_EPC    = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C,
        EXC_TR   = 5'h0D,
        EXC_ERET = 5'h0E
    } exc_code_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } exc_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: interrupt > ri > syscall > brk > trap > ovf > eret.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [EXC_VEC_W-1:0] exc_vec_i,
    input  logic                 int_pending_i,
    output logic                 hit_o,
    output exc_code_e            code_o
);

    always_comb begin
        hit_o  = 1'b1;
        code_o = EXC_INT;
        if (int_pending_i) begin
            code_o = EXC_INT;
        end else if (exc_vec_i[EXC_BIT_RI]) begin
            code_o = EXC_RI;
        end else if (exc_vec_i[EXC_BIT_SYSCALL]) begin
            code_o = EXC_SYS;
        end else if (exc_vec_i[EXC_BIT_BRK]) begin
            code_o = EXC_BP;
        end else if (exc_vec_i[EXC_BIT_TRAP]) begin
            code_o = EXC_TR;
        end else if (exc_vec_i[EXC_BIT_OVF]) begin
            code_o = EXC_OV;
        end else if (exc_vec_i[EXC_BIT_ERET]) begin
            code_o = EXC_ERET;
        end else begin
            hit_o  = 1'b0;
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Commit-point exception controller: forwards WB cp0 writes, picks the top exception,
// flushes and redirects fetch. Interrupt detection is enabled by defining CP0_EXC_INT_EN.
module cp0_exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [31:0]          i_pc,
    input  logic                 i_in_delay_slot,
    input  logic [EXC_VEC_W-1:0] i_exc_vec,
    input  logic [31:0]          i_cp0_status,
    input  logic [31:0]          i_cp0_cause,
    input  logic [31:0]          i_cp0_epc,
    input  logic                 i_wb_cp0_we,
    input  logic [4:0]           i_wb_cp0_addr,
    input  logic [31:0]          i_wb_cp0_data,
    output logic                 o_flush,
    output logic [31:0]          o_new_pc,
    output logic                 o_exc_we,
    output logic [4:0]           o_exc_code,
    output logic                 o_exc_bd,
    output logic [31:0]          o_exc_epc,
    output logic                 o_exl_set,
    output logic                 o_exl_clr
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

    logic [31:0] fwd_status;
    logic [31:0] fwd_cause;
    logic [31:0] fwd_epc;
    logic        int_pending;
    logic        prio_hit;
    exc_code_e   prio_code;
    logic        is_eret;
    logic        take;
    logic        unused_fwd;

    exc_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            flush_q, flush_d;
    logic [31:0]     new_pc_q, new_pc_d;
    logic            exc_we_q, exc_we_d;
    logic [4:0]      code_q, code_d;
    logic            bd_q, bd_d;
    logic [31:0]     epc_q, epc_d;
    logic            exl_set_q, exl_set_d;
    logic            exl_clr_q, exl_clr_d;

    // A WB write lands in cp0 only at the next edge, so the MEM decision sees it here
    always_comb begin
        fwd_status = i_cp0_status;
        fwd_cause  = i_cp0_cause;
        fwd_epc    = i_cp0_epc;
        if (i_wb_cp0_we) begin
            if (i_wb_cp0_addr == CP0_ADDR_STATUS) begin
                fwd_status = i_wb_cp0_data;
            end
            if (i_wb_cp0_addr == CP0_ADDR_EPC) begin
                fwd_epc = i_wb_cp0_data;
            end
            if (i_wb_cp0_addr == CP0_ADDR_CAUSE) begin
                fwd_cause[9:8] = i_wb_cp0_data[9:8];
                fwd_cause[23]  = i_wb_cp0_data[23];
                fwd_cause[22]  = i_wb_cp0_data[22];
            end
        end
    end

`ifdef CP0_EXC_INT_EN
    assign int_pending = fwd_status[0] && !fwd_status[1]
                         && (|(fwd_status[15:8] & fwd_cause[15:8]));
    assign unused_fwd  = ^{fwd_status[31:16], fwd_status[7:2],
                           fwd_cause[31:16], fwd_cause[7:0]};
`else
    assign int_pending = 1'b0;
    assign unused_fwd  = ^{fwd_status, fwd_cause};
`endif

    exc_prio_enc u_prio (
        .exc_vec_i     (i_exc_vec),
        .int_pending_i (int_pending),
        .hit_o         (prio_hit),
        .code_o        (prio_code)
    );

    assign is_eret = (prio_code == EXC_ERET);
    assign take    = (state_q == ST_IDLE) && i_valid && prio_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (take && (FLUSH_CYCLES > 1)) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // cnt_q counts flush cycles already elapsed past the first one
    always_comb begin
        flush_d   = 1'b0;
        new_pc_d  = new_pc_q;
        exc_we_d  = 1'b0;
        code_d    = code_q;
        bd_d      = bd_q;
        epc_d     = epc_q;
        exl_set_d = 1'b0;
        exl_clr_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    flush_d   = 1'b1;
                    exc_we_d  = 1'b1;
                    code_d    = prio_code;
                    bd_d      = i_in_delay_slot;
                    epc_d     = i_in_delay_slot ? (i_pc - 32'd4) : i_pc;
                    new_pc_d  = is_eret ? fwd_epc : EXC_VECTOR;
                    exl_set_d = !is_eret;
                    exl_clr_d = is_eret;
                end
            end
            ST_HOLD: begin
                flush_d = (cnt_q != CNT_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flush_q   <= 1'b0;
            new_pc_q  <= '0;
            exc_we_q  <= 1'b0;
            code_q    <= '0;
            bd_q      <= 1'b0;
            epc_q     <= '0;
            exl_set_q <= 1'b0;
            exl_clr_q <= 1'b0;
        end else begin
            flush_q   <= flush_d;
            new_pc_q  <= new_pc_d;
            exc_we_q  <= exc_we_d;
            code_q    <= code_d;
            bd_q      <= bd_d;
            epc_q     <= epc_d;
            exl_set_q <= exl_set_d;
            exl_clr_q <= exl_clr_d;
        end
    end

    assign o_flush    = flush_q;
    assign o_new_pc   = new_pc_q;
    assign o_exc_we   = exc_we_q;
    assign o_exc_code = code_q;
    assign o_exc_bd   = bd_q;
    assign o_exc_epc  = epc_q;
    assign o_exl_set  = exl_set_q;
    assign o_exl_clr  = exl_clr_q;

endmodule
